game_round_ctrl: RTL and testbench

//  Round controller downstream of the LFSR/comparator match stage. Sequences one round:

---
 rtl/game_round_ctrl_pkg.sv | 23 ++
 rtl/game_round_ctrl_bcd_counter2.sv | 50 +++++
 rtl/game_round_ctrl.sv | 149 ++++++++++++++
 tb/tb_game_round_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/game_round_ctrl_pkg.sv
// Shared types and constants for the game round controller.
package game_round_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSpin  = 3'd1,
    StGuess = 3'd2,
    StWin   = 3'd3,
    StLose  = 3'd4
  } state_e;

  localparam logic [3:0]  BcdMax     = 4'd9;
  localparam int unsigned RedWidth   = 18;
  localparam int unsigned GreenWidth = 8;
  localparam int unsigned PhaseWidth = 8;

  // True when the two BCD digits encode the decimal value val.
  function automatic logic bcd_is(input logic [3:0] tens, input logic [3:0] ones,
                                  input int unsigned val);
    return (tens == 4'(val / 10)) && (ones == 4'(val % 10));
  endfunction

endpackage

// File: rtl/game_round_ctrl_bcd_counter2.sv
// Two-digit BCD up-counter with synchronous clear and optional saturation at 99.
module bcd_counter2
  import game_round_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       clear_b,
  input  logic       inc,
  input  logic       clr,
  input  logic       sat,
  output logic [3:0] ones,
  output logic [3:0] tens
);

  logic [3:0] ones_d, tens_d;

  always_comb begin
    ones_d = ones;
    tens_d = tens;
    if (clr) begin
      ones_d = 4'd0;
      tens_d = 4'd0;
    end else if (inc) begin
      if (ones == BcdMax) begin
        if (tens == BcdMax) begin
          // Saturating counters hold at 99; others wrap to 00.
          if (!sat) begin
            ones_d = 4'd0;
            tens_d = 4'd0;
          end
        end else begin
          ones_d = 4'd0;
          tens_d = tens + 4'd1;
        end
      end else begin
        ones_d = ones + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      ones <= 4'd0;
      tens <= 4'd0;
    end else begin
      ones <= ones_d;
      tens <= tens_d;
    end
  end

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer: spin targets, time the guess window, judge submits, keep score, flash LEDs.
module game_round_ctrl
  import game_round_ctrl_pkg::*;
#(
  parameter int unsigned ROUND_SECS = 60,
  parameter int unsigned SPIN_TICKS = 2,
  parameter int unsigned SHOW_TICKS = 3,
  parameter int unsigned MAX_MISSES = 3
) (
  input  logic                  clk,
  input  logic                  clear_b,
  input  logic                  tick_1hz,
  input  logic                  start,
  input  logic                  submit,
  input  logic                  match,
  output logic                  lfsr_run,
  output logic                  round_active,
  output logic [3:0]            sec_ones,
  output logic [3:0]            sec_tens,
  output logic [3:0]            score_ones,
  output logic [3:0]            score_tens,
  output logic [2:0]            misses,
  output logic [RedWidth-1:0]   led_red,
  output logic [GreenWidth-1:0] led_green
);

  state_e                state_q, state_d;
  logic [PhaseWidth-1:0] phase_q, phase_d;
  logic [2:0]            misses_q, misses_d, misses_inc;
  logic                  sec_inc, sec_clr, score_inc, last_sec;
  logic                  lfsr_run_d, round_active_d;
  logic [RedWidth-1:0]   led_red_d;
  logic [GreenWidth-1:0] led_green_d;

  assign misses_inc = misses_q + 3'd1;
  assign last_sec   = tick_1hz && bcd_is(sec_tens, sec_ones, ROUND_SECS - 1);

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    misses_d  = misses_q;
    sec_inc   = 1'b0;
    sec_clr   = 1'b0;
    score_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StSpin;
          sec_clr  = 1'b1;
          misses_d = 3'd0;
          phase_d  = '0;
        end
      end
      StSpin: begin
        if (tick_1hz) begin
          if (phase_q == PhaseWidth'(SPIN_TICKS - 1)) begin
            state_d = StGuess;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      StGuess: begin
        // Ordering: correct submit, then timeout, then miss limit, then plain tick.
        if (submit && match) begin
          state_d   = StWin;
          score_inc = 1'b1;
          phase_d   = '0;
        end else if (last_sec) begin
          state_d = StLose;
          sec_inc = 1'b1;
          phase_d = '0;
          if (submit) misses_d = misses_inc;
        end else if (submit) begin
          misses_d = misses_inc;
          if (misses_inc == 3'(MAX_MISSES)) begin
            state_d = StLose;
            phase_d = '0;
          end else if (tick_1hz) begin
            sec_inc = 1'b1;
          end
        end else if (tick_1hz) begin
          sec_inc = 1'b1;
        end
      end
      StWin, StLose: begin
        if (tick_1hz) begin
          if (phase_q == PhaseWidth'(SHOW_TICKS - 1)) begin
            state_d = StIdle;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are computed from next state so they register alongside it.
    lfsr_run_d     = (state_d == StSpin);
    round_active_d = (state_d == StSpin) || (state_d == StGuess);
    led_green_d    = ((state_d == StWin)  && !phase_d[0]) ? '1 : '0;
    led_red_d      = ((state_d == StLose) && !phase_d[0]) ? '1 : '0;
  end

  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      state_q      <= StIdle;
      phase_q      <= '0;
      misses_q     <= 3'd0;
      lfsr_run     <= 1'b0;
      round_active <= 1'b0;
      led_red      <= '0;
      led_green    <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      misses_q     <= misses_d;
      lfsr_run     <= lfsr_run_d;
      round_active <= round_active_d;
      led_red      <= led_red_d;
      led_green    <= led_green_d;
    end
  end

  assign misses = misses_q;

  bcd_counter2 u_sec (
    .clk     (clk),
    .clear_b (clear_b),
    .inc     (sec_inc),
    .clr     (sec_clr),
    .sat     (1'b0),
    .ones    (sec_ones),
    .tens    (sec_tens)
  );

  bcd_counter2 u_score (
    .clk     (clk),
    .clear_b (clear_b),
    .inc     (score_inc),
    .clr     (1'b0),
    .sat     (1'b1),
    .ones    (score_ones),
    .tens    (score_tens)
  );

endmodule

// File: tb/tb_game_round_ctrl.sv
// Scoreboard bench for game_round_ctrl: stimulus queues expected snapshots, monitor compares.
module tb_game_round_ctrl;

  logic        clk = 1'b0;
  logic        clear_b = 1'b0;
  logic        tick_1hz = 1'b0, start = 1'b0, submit = 1'b0, match = 1'b0;
  logic        lfsr_run, round_active;
  logic [3:0]  sec_ones, sec_tens, score_ones, score_tens;
  logic [2:0]  misses;
  logic [17:0] led_red;
  logic [7:0]  led_green;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        lfsr;
    logic        act;
    logic [7:0]  sec;
    logic [7:0]  score;
    logic [2:0]  mis;
    logic [17:0] red;
    logic [7:0]  green;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  game_round_ctrl dut (
    .clk          (clk),
    .clear_b      (clear_b),
    .tick_1hz     (tick_1hz),
    .start        (start),
    .submit       (submit),
    .match        (match),
    .lfsr_run     (lfsr_run),
    .round_active (round_active),
    .sec_ones     (sec_ones),
    .sec_tens     (sec_tens),
    .score_ones   (score_ones),
    .score_tens   (score_tens),
    .misses       (misses),
    .led_red      (led_red),
    .led_green    (led_green)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are stable by the falling edge; compare everything queued so far.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      checks++;
      if (lfsr_run !== cur.lfsr || round_active !== cur.act ||
          {sec_tens, sec_ones} !== cur.sec || {score_tens, score_ones} !== cur.score ||
          misses !== cur.mis || led_red !== cur.red || led_green !== cur.green) begin
        failures++;
        $display("FAIL %s: got lfsr=%b act=%b sec=%h score=%h mis=%0d red=%h green=%h; want lfsr=%b act=%b sec=%h score=%h mis=%0d red=%h green=%h",
                 cur.name, lfsr_run, round_active, {sec_tens, sec_ones},
                 {score_tens, score_ones}, misses, led_red, led_green,
                 cur.lfsr, cur.act, cur.sec, cur.score, cur.mis, cur.red, cur.green);
      end
    end
  end

  task automatic e(input string n, input logic lf, input logic ac, input logic [7:0] sc,
                   input logic [7:0] scr, input logic [2:0] mi, input logic [17:0] rd,
                   input logic [7:0] gr);
    exp_t x;
    x.name = n; x.lfsr = lf; x.act = ac; x.sec = sc; x.score = scr;
    x.mis = mi; x.red = rd; x.green = gr;
    sb.push_back(x);
  endtask

  // Drive one cycle of inputs; returns 1 time unit after the sampling edge.
  task automatic cyc(input logic t, input logic s, input logic sb_in, input logic m);
    tick_1hz = t; start = s; submit = sb_in; match = m;
    @(posedge clk);
    #1;
    tick_1hz = 1'b0; start = 1'b0; submit = 1'b0; match = 1'b0;
  endtask

  task automatic tk();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic win_round();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    tk(); tk();
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    tk(); tk(); tk();
  endtask

  localparam logic [17:0] R1 = 18'h3ffff;
  localparam logic [7:0]  G1 = 8'hff;

  initial begin
    @(posedge clk); #1;
    e("in_reset", 0, 0, 8'h00, 8'h00, 0, 0, 0);
    @(posedge clk); #1;
    clear_b = 1'b1;
    for (int i = 0; i < 5; i++) tk();
    e("idle_after_ticks", 0, 0, 8'h00, 8'h00, 0, 0, 0);

    // Round 1: spin, 12 seconds, correct submit.
    cyc(0, 1, 0, 0);   e("spin_entry", 1, 1, 8'h00, 8'h00, 0, 0, 0);
    tk();              e("spin_tick1", 1, 1, 8'h00, 8'h00, 0, 0, 0);
    tk();              e("guess_open", 0, 1, 8'h00, 8'h00, 0, 0, 0);
    for (int i = 0; i < 10; i++) tk();
    e("sec_carry10", 0, 1, 8'h10, 8'h00, 0, 0, 0);
    tk(); tk();        e("sec12", 0, 1, 8'h12, 8'h00, 0, 0, 0);
    cyc(0, 0, 1, 1);   e("win_entry", 0, 0, 8'h12, 8'h01, 0, 0, G1);
    tk();              e("win_t1", 0, 0, 8'h12, 8'h01, 0, 0, 8'h00);
    tk();              e("win_t2", 0, 0, 8'h12, 8'h01, 0, 0, G1);
    tk();              e("win_exit", 0, 0, 8'h12, 8'h01, 0, 0, 8'h00);

    // Round 2: three wrong submits.
    cyc(0, 1, 0, 0);   e("r2_spin", 1, 1, 8'h00, 8'h01, 0, 0, 0);
    tk(); tk();        e("r2_guess", 0, 1, 8'h00, 8'h01, 0, 0, 0);
    cyc(0, 0, 0, 1);   e("match_no_submit", 0, 1, 8'h00, 8'h01, 0, 0, 0);
    cyc(0, 0, 1, 0);   e("miss1", 0, 1, 8'h00, 8'h01, 1, 0, 0);
    cyc(1, 0, 1, 0);   e("miss2_tick", 0, 1, 8'h01, 8'h01, 2, 0, 0);
    cyc(0, 0, 1, 0);   e("miss3_lose", 0, 0, 8'h01, 8'h01, 3, R1, 0);
    tk();              e("lose_t1", 0, 0, 8'h01, 8'h01, 3, 0, 0);
    tk();              e("lose_t2", 0, 0, 8'h01, 8'h01, 3, R1, 0);
    tk();              e("lose_exit", 0, 0, 8'h01, 8'h01, 3, 0, 0);

    // Round 3: timeout.
    cyc(0, 1, 0, 0);
    tk(); tk();
    for (int i = 0; i < 59; i++) tk();
    e("sec59", 0, 1, 8'h59, 8'h01, 0, 0, 0);
    tk();              e("timeout_lose", 0, 0, 8'h60, 8'h01, 0, R1, 0);
    cyc(0, 1, 0, 0);   e("start_ignored", 0, 0, 8'h60, 8'h01, 0, R1, 0);
    tk(); tk(); tk();  e("timeout_exit", 0, 0, 8'h60, 8'h01, 0, 0, 0);

    // Round 4: start with tick (tick not counted), win on the 60th tick.
    cyc(1, 1, 0, 0);   e("start_tick", 1, 1, 8'h00, 8'h01, 0, 0, 0);
    tk();              e("start_tick_spin", 1, 1, 8'h00, 8'h01, 0, 0, 0);
    tk();
    for (int i = 0; i < 59; i++) tk();
    cyc(1, 0, 1, 1);   e("win_beats_timeout", 0, 0, 8'h59, 8'h02, 0, 0, G1);
    tk(); tk(); tk();

    // Score saturation.
    for (int i = 0; i < 97; i++) win_round();
    e("score99", 0, 0, 8'h00, 8'h99, 0, 0, 0);
    cyc(0, 1, 0, 0); tk(); tk();
    cyc(0, 0, 1, 1);   e("score_sat", 0, 0, 8'h00, 8'h99, 0, 0, G1);
    tk(); tk(); tk();

    // Async reset mid-round.
    cyc(0, 1, 0, 0); tk(); tk(); tk();
    e("pre_reset", 0, 1, 8'h01, 8'h99, 0, 0, 0);
    @(negedge clk); #2;
    clear_b = 1'b0;
    #1;
    e("async_reset", 0, 0, 8'h00, 8'h00, 0, 0, 0);
    @(posedge clk); #1;
    clear_b = 1'b1;
    tk();              e("post_reset_idle", 0, 0, 8'h00, 8'h00, 0, 0, 0);

    @(negedge clk); #1;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
